time_counter: RTL

Time-of-day keeper that sits directly upstream of the alarm comparator. It advances a 24-hour BCD clock (HH:MM:SS) on a once-per-second tick and drives the four BCD digits `curHour1`, `curHour0`, `curMin1`, `curMin0` that the alarm block compares against its stored alarm time. Supports a validated direct time load and per-field increment for user time setting. It also emits a one-cycle minute-rollover pulse.

---
 rtl/time_pkg.sv | 22 ++
 rtl/time_counter_if.sv | 31 +++
 rtl/bcd_mod_counter.sv | 65 ++++++
 rtl/time_counter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared types, limits and the load-validation helper for the time-of-day keeper.
package time_pkg;

    typedef logic [3:0] bcd_t;

    // Two-digit BCD field: tens digit in d1, units digit in d0.
    typedef struct packed {
        bcd_t d1;
        bcd_t d0;
    } bcd2_t;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    // True when h1h0:m1m0 is a legal 24-hour BCD time.
    function automatic logic bcd_valid_time(bcd_t h1, bcd_t h0, bcd_t m1, bcd_t m0);
        return (h1 <= 4'd2) && (h0 <= 4'd9) && ((h1 < 4'd2) || (h0 <= 4'd3))
            && (m1 <= 4'd5) && (m0 <= 4'd9);
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// Control and time-display bundle between the time-setting logic and time_counter.
interface time_counter_if;
    import time_pkg::*;

    logic tick;
    logic load;
    bcd_t loadHour1;
    bcd_t loadHour0;
    bcd_t loadMin1;
    bcd_t loadMin0;
    logic incMin;
    logic incHour;
    bcd_t curHour1;
    bcd_t curHour0;
    bcd_t curMin1;
    bcd_t curMin0;
    bcd_t curSec1;
    bcd_t curSec0;
    logic minPulse;

    modport master (
        output tick, load, loadHour1, loadHour0, loadMin1, loadMin0, incMin, incHour,
        input  curHour1, curHour0, curMin1, curMin0, curSec1, curSec0, minPulse
    );

    modport slave (
        input  tick, load, loadHour1, loadHour0, loadMin1, loadMin0, incMin, incHour,
        output curHour1, curHour0, curMin1, curMin0, curSec1, curSec0, minPulse
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-(MAX+1) counter with load and clear.
// Priority: load > clr > inc. carry is combinational and flags a wrap on this inc.
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  inc,
    input  logic  clr,
    input  logic  load,
    input  bcd2_t load_val,
    output logic  carry,
    output bcd_t  dig1,
    output bcd_t  dig0
);

    localparam bcd_t MAX1 = bcd_t'(MAX / 10);
    localparam bcd_t MAX0 = bcd_t'(MAX % 10);

    bcd_t dig1_q, dig1_d;
    bcd_t dig0_q, dig0_d;
    logic at_max;

    assign at_max = (dig1_q == MAX1) && (dig0_q == MAX0);
    assign carry  = inc && at_max;
    assign dig1   = dig1_q;
    assign dig0   = dig0_q;

    // Next-value selection for the two digits.
    always_comb begin
        dig1_d = dig1_q;
        dig0_d = dig0_q;
        if (load) begin
            dig1_d = load_val.d1;
            dig0_d = load_val.d0;
        end else if (clr) begin
            dig1_d = 4'd0;
            dig0_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                dig1_d = 4'd0;
                dig0_d = 4'd0;
            end else if (dig0_q == 4'd9) begin
                dig1_d = dig1_q + 4'd1;
                dig0_d = 4'd0;
            end else begin
                dig0_d = dig0_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig1_q <= 4'd0;
            dig0_q <= 4'd0;
        end else begin
            dig1_q <= dig1_d;
            dig0_q <= dig0_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD time-of-day keeper with validated load, per-field increment and
// a minute-rollover pulse. Optional feature macro: TIME_PRESCALER_EN (internal
// 1 Hz tick from a PRESCALE-cycle counter; the tick input is then unused).
module time_counter
    import time_pkg::*;
`ifdef TIME_PRESCALER_EN
#(
    parameter int unsigned PRESCALE = 50_000_000
)
`endif
(
    input  logic          clk,
    input  logic          reset,
    time_counter_if.slave bus
);

    logic  load_ok;
    logic  inc_min;
    logic  inc_hour;
    logic  inc_any;
    logic  tick_int;
    logic  tick_eff;
    logic  sec_carry;
    logic  min_carry;
    logic  min_inc;
    logic  hour_inc;
    logic  day_wrap_unused;
    logic  min_pulse_q, min_pulse_d;
    bcd2_t load_min;
    bcd2_t load_hour;

    assign load_ok   = bus.load && bcd_valid_time(bus.loadHour1, bus.loadHour0,
                                                  bus.loadMin1, bus.loadMin0);
    assign inc_min   = bus.incMin && !load_ok;
    assign inc_hour  = bus.incHour && !load_ok;
    assign inc_any   = inc_min || inc_hour;
    assign load_min  = '{d1: bus.loadMin1, d0: bus.loadMin0};
    assign load_hour = '{d1: bus.loadHour1, d0: bus.loadHour0};

`ifdef TIME_PRESCALER_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick_int = (presc_q == PRESC_LAST);

    // Prescaler next value: restart on accepted load, wrap at PRESCALE-1.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (load_ok || tick_int) begin
            presc_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick_int = bus.tick;
`endif

    // A tick only advances time when no load or increment claims the cycle.
    assign tick_eff = tick_int && !load_ok && !inc_any;
    assign min_inc  = inc_min || sec_carry;
    assign hour_inc = inc_hour || (sec_carry && min_carry);

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .reset    (reset),
        .inc      (tick_eff),
        .clr      (load_ok || inc_any),
        .load     (1'b0),
        .load_val ('0),
        .carry    (sec_carry),
        .dig1     (bus.curSec1),
        .dig0     (bus.curSec0)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .reset    (reset),
        .inc      (min_inc),
        .clr      (1'b0),
        .load     (load_ok),
        .load_val (load_min),
        .carry    (min_carry),
        .dig1     (bus.curMin1),
        .dig0     (bus.curMin0)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .reset    (reset),
        .inc      (hour_inc),
        .clr      (1'b0),
        .load     (load_ok),
        .load_val (load_hour),
        .carry    (day_wrap_unused),
        .dig1     (bus.curHour1),
        .dig0     (bus.curHour0)
    );

    assign min_pulse_d  = sec_carry;
    assign bus.minPulse = min_pulse_q;

    // Minute pulse register, aligned with the new minute becoming visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_pulse_q <= 1'b0;
        end else begin
            min_pulse_q <= min_pulse_d;
        end
    end

endmodule
